// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST pattern engine:
// FSM states, maximal-length LFSR taps and the MISR polynomial.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [15:0] MISR_POLY = 16'h1021;

   // Bit k-1 set means tap k (1-based) feeds the XOR.
   localparam logic [15:0] LFSR_TAPS [3:16] = '{
      16'h0006, 16'h000C, 16'h0014, 16'h0030,
      16'h0060, 16'h00B8, 16'h0110, 16'h0240,
      16'h0500, 16'h0829, 16'h100D, 16'h2015,
      16'h6000, 16'hD008
   };

endpackage

// File: rtl/bist_pattern_engine_if.sv
// Control, CUT and result signals of the BIST pattern engine.
// The engine takes the slave side; the harness takes the master side.
interface bist_pattern_engine_if #(
   parameter int N_IN  = 5,
   parameter int N_OUT = 1,
   parameter int SIG_W = 16
);

   logic             start;
   logic             abort;
   logic             mode;
   logic [SIG_W-1:0] golden_sig;
   logic [N_IN-1:0]  cut_in;
   logic [N_OUT-1:0] cut_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [SIG_W-1:0] signature;
   logic [N_IN:0]    pattern_count;

   modport master (
      output start, abort, mode, golden_sig, cut_out,
      input  cut_in, busy, done, pass, signature, pattern_count
   );

   modport slave (
      input  start, abort, mode, golden_sig, cut_out,
      output cut_in, busy, done, pass, signature, pattern_count
   );

endinterface

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift left, fold MSB through POLY,
// XOR in the zero-extended CUT response. clr has priority over en.
module bist_misr
   import bist_pkg::*;
#(
   parameter int               SIG_W = 16,
   parameter int               N_OUT = 1,
   parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [N_OUT-1:0] din,
   output logic [SIG_W-1:0] sig,
   output logic [SIG_W-1:0] sig_next
);

   if (N_OUT > SIG_W) begin : g_bad_width
      $error("bist_misr: N_OUT must not exceed SIG_W");
   end

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_next = (sig_q << 1)
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ SIG_W'(din);
      sig_d = sig_q;
      if (clr) begin
         sig_d = '0;
      end else if (en) begin
         sig_d = sig_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/bist_pattern_engine.sv
// BIST engine: exhaustive or LFSR patterns into a combinational CUT,
// response compacted by bist_misr and compared with golden_sig.
module bist_pattern_engine
   import bist_pkg::*;
#(
   parameter int N_IN  = 5,
   parameter int N_OUT = 1,
   parameter int SIG_W = 16
) (
   input logic                   clk,
   input logic                   rst_n,
   bist_pattern_engine_if.slave  bus
);

   if (N_IN < 3 || N_IN > 16) begin : g_bad_n_in
      $error("bist_pattern_engine: N_IN must be 3..16");
   end

   localparam int PW = N_IN + 1;
   localparam logic [N_IN-1:0] TAPS = LFSR_TAPS[N_IN][N_IN-1:0];
   localparam logic [PW-1:0] LAST_EXH  = PW'((1 << N_IN) - 1);
   localparam logic [PW-1:0] LAST_LFSR = PW'((1 << N_IN) - 2);

   state_t          state_q, state_d;
   logic            mode_q, mode_d;
   logic [PW-1:0]   pat_q, pat_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic             misr_clr;
   logic             misr_en;
   logic [SIG_W-1:0] sig;
   logic [SIG_W-1:0] sig_next;
   logic             last;
   logic [PW-1:0]    pat_adv;

   bist_misr #(
      .SIG_W (SIG_W),
      .N_OUT (N_OUT)
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (misr_clr),
      .en       (misr_en),
      .din      (bus.cut_out),
      .sig      (sig),
      .sig_next (sig_next)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      pat_d    = pat_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      misr_clr = 1'b0;
      misr_en  = 1'b0;

      // Terminal test on the count of patterns already compacted.
      last = (cnt_q == (mode_q ? LAST_LFSR : LAST_EXH));
      pat_adv = mode_q
              ? {1'b0, pat_q[N_IN-2:0], ^(pat_q[N_IN-1:0] & TAPS)}
              : pat_q + 1'b1;

      unique case (state_q)
         IDLE, DONE: begin
            if (bus.abort) begin
               state_d = IDLE;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (bus.start) begin
               state_d  = RUN;
               mode_d   = bus.mode;
               misr_clr = 1'b1;
               cnt_d    = '0;
               pat_d    = bus.mode ? PW'({N_IN{1'b1}}) : '0;
               busy_d   = 1'b1;
               done_d   = 1'b0;
               pass_d   = 1'b0;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               pat_d   = '0;
            end else begin
               misr_en = 1'b1;
               cnt_d   = cnt_q + 1'b1;
               if (last) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (sig_next == bus.golden_sig);
                  pat_d   = '0;
               end else begin
                  pat_d = pat_adv;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            pat_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mode_q  <= 1'b0;
         pat_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pat_q   <= pat_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.cut_in        = pat_q[N_IN-1:0];
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.signature     = sig;
   assign bus.pattern_count = cnt_q;

endmodule

// File: tb/tb_bist_pattern_engine.sv
// Directed bench for bist_pattern_engine (N_IN=5, N_OUT=1, SIG_W=16):
// full runs from a vector table plus abort / reset corner sequences.
module tb_bist_pattern_engine;

   localparam int N_IN  = 5;
   localparam int N_OUT = 1;
   localparam int SIG_W = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] cut_sel = 2'd0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   bist_pattern_engine_if #(
      .N_IN (N_IN), .N_OUT (N_OUT), .SIG_W (SIG_W)
   ) bus ();

   bist_pattern_engine #(
      .N_IN (N_IN), .N_OUT (N_OUT), .SIG_W (SIG_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // CUT stand-ins: 0 = tied low, 1 = (cut_in == 0), 2 = parity.
   assign bus.cut_out = (cut_sel == 2'd1) ? 1'(bus.cut_in == '0)
                      : (cut_sel == 2'd2) ? ^bus.cut_in
                      : 1'b0;

   typedef struct {
      logic        mode;
      logic [1:0]  cut;
      logic        flip;
      logic [5:0]  exp_cnt;
      logic        exp_pass;
      logic [15:0] exp_sig;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic cutf(input logic [1:0] sel,
                                 input logic [4:0] p);
      if (sel == 2'd1) return (p == 5'd0);
      if (sel == 2'd2) return ^p;
      return 1'b0;
   endfunction

   function automatic logic [15:0] mstep(input logic [15:0] s,
                                         input logic b);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)
             ^ {15'd0, b};
   endfunction

   function automatic logic [15:0] model_sig(input logic mode,
                                             input logic [1:0] sel);
      logic [15:0] s;
      logic [4:0]  l;
      s = '0;
      l = 5'h1f;
      if (!mode) begin
         for (int i = 0; i < 32; i++) s = mstep(s, cutf(sel, 5'(i)));
      end else begin
         for (int i = 0; i < 31; i++) begin
            s = mstep(s, cutf(sel, l));
            l = {l[3:0], l[4] ^ l[2]};
         end
      end
      return s;
   endfunction

   task automatic run_vec(input vec_t v);
      logic       seen [32];
      int         cyc;
      logic [4:0] p;
      for (int i = 0; i < 32; i++) seen[i] = 1'b0;
      @(negedge clk);
      cut_sel        = v.cut;
      bus.mode       = v.mode;
      bus.golden_sig = v.exp_sig ^ {15'd0, v.flip};
      bus.start      = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 0;
      while (bus.busy === 1'b1 && cyc < 100) begin
         p = bus.cut_in;
         if (!v.mode) begin
            check("exh_pattern", 32'(p), 32'(cyc[4:0]));
         end else begin
            if (cyc == 0) check("lfsr_first", 32'(p), 32'h1f);
            check("lfsr_nonzero_fresh", {30'd0, p == 5'd0, seen[p]}, 0);
            seen[p] = 1'b1;
         end
         if (v.cut == 2'd1 && !v.mode && cyc == 1)
            check("sig_first_edge", 32'(bus.signature), 32'h0001);
         if (v.cut == 2'd1 && !v.mode && cyc == 16)
            check("sig_after_15", 32'(bus.signature), 32'h8000);
         cyc++;
         @(negedge clk);
      end
      check("busy_cycles", cyc, 32'(v.exp_cnt));
      check("done", 32'(bus.done), 1);
      check("pass", 32'(bus.pass), 32'(v.exp_pass));
      check("pattern_count", 32'(bus.pattern_count), 32'(v.exp_cnt));
      check("signature", 32'(bus.signature), 32'(v.exp_sig));
      check("cut_in_done", 32'(bus.cut_in), 0);
   endtask

   initial begin
      int n;
      bus.start      = 1'b0;
      bus.abort      = 1'b0;
      bus.mode       = 1'b0;
      bus.golden_sig = '0;

      vecs[0] = '{1'b0, 2'd0, 1'b0, 6'd32, 1'b1, 16'h0000};
      vecs[1] = '{1'b1, 2'd0, 1'b0, 6'd31, 1'b1, 16'h0000};
      vecs[2] = '{1'b0, 2'd1, 1'b0, 6'd32, 1'b1, model_sig(1'b0, 2'd1)};
      vecs[3] = '{1'b0, 2'd1, 1'b1, 6'd32, 1'b0, model_sig(1'b0, 2'd1)};
      vecs[4] = '{1'b0, 2'd2, 1'b0, 6'd32, 1'b1, model_sig(1'b0, 2'd2)};
      vecs[5] = '{1'b1, 2'd2, 1'b1, 6'd31, 1'b0, model_sig(1'b1, 2'd2)};

      #12;
      check("rst_cut_in", 32'(bus.cut_in), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_pass", 32'(bus.pass), 0);
      check("rst_signature", 32'(bus.signature), 0);
      check("rst_count", 32'(bus.pattern_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // abort beats start in IDLE
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      check("abort_wins_busy", 32'(bus.busy), 0);
      check("abort_wins_cut_in", 32'(bus.cut_in), 0);

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // abort out of DONE keeps the signature
      @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("done_abort_done", 32'(bus.done), 0);
      check("done_abort_pass", 32'(bus.pass), 0);
      check("done_abort_sig", 32'(bus.signature), 32'(vecs[5].exp_sig));

      // abort at pattern_count 10, with a stray start mid-run
      cut_sel   = 2'd1;
      bus.mode  = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.pattern_count != 6'd10 && n < 100) begin
         bus.start = (bus.pattern_count == 6'd4);
         check("stray_start_seq", 32'(bus.cut_in), 32'(bus.pattern_count[4:0]));
         n++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("reach_count_10", 32'(n < 100), 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_cut_in", 32'(bus.cut_in), 0);
      check("abort_count", 32'(bus.pattern_count), 10);
      check("abort_sig", 32'(bus.signature), 32'h0200);
      @(negedge clk);
      @(negedge clk);
      check("abort_count_hold", 32'(bus.pattern_count), 10);
      check("abort_done", 32'(bus.done), 0);

      // asynchronous reset at pattern_count 7
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.pattern_count != 6'd7 && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("reach_count_7", 32'(n < 100), 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_cut_in", 32'(bus.cut_in), 0);
      check("arst_busy", 32'(bus.busy), 0);
      check("arst_done", 32'(bus.done), 0);
      check("arst_pass", 32'(bus.pass), 0);
      check("arst_signature", 32'(bus.signature), 0);
      check("arst_count", 32'(bus.pattern_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bist_pattern_engine.md
Name: bist_pattern_engine

Overview:
- Parametrised built-in self-test engine for the team's combinational fault-analysis circuits; generalises the fixed 5-input hand-written stimulus sequence to N_IN inputs.
- Drives every test pattern into a combinational circuit-under-test (CUT) and compacts the CUT response into a multiple-input signature register (MISR).
- Compares the final signature with a golden value, so stuck-at faults injected into a CUT show up as a pass/fail flag.
- Sits beside any circuitN instance; the CUT is purely combinational and responds within the same cycle.

Parameters:
- N_IN, 5, CUT input count; legal range 3..16.
- N_OUT, 1, CUT output count; legal range 1..SIG_W.
- SIG_W, 16, MISR and signature width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request; sampled only in IDLE or DONE.
- abort  input  1  synchronous abort; returns the block to IDLE.
- mode  input  1  0 = exhaustive counter, 1 = pseudo-random LFSR; latched on accepted start.
- golden_sig  input  SIG_W  expected final signature; sampled in the last RUN cycle.
- cut_in  output  N_IN  pattern driven to the CUT (bit 0 = x1).
- cut_out  input  N_OUT  CUT response.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- pass  output  1  valid while done; 1 when signature == golden_sig.
- signature  output  SIG_W  live MISR contents.
- pattern_count  output  N_IN+1  number of patterns compacted so far.

Behaviour:
- Reset (rst_n low, any state, including mid-run): state IDLE; cut_in, busy, done, pass, signature and pattern_count all 0; latched mode 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start:
  - latch mode;
  - clear signature and pattern_count;
  - load the first pattern: 0 in exhaustive mode, all-ones in LFSR mode.
  - The first pattern appears on cut_in in the cycle after start is seen.
- RUN, every rising edge:
  - signature_next = (signature << 1) ^ (signature[SIG_W-1] ? MISR_POLY : 0) ^ zero-extended cut_out;
  - pattern_count increments;
  - cut_in advances to the next pattern.
- Exhaustive mode: cut_in counts 0, 1, ..., 2^N_IN-1 (2^N_IN patterns).
- LFSR mode: Fibonacci LFSR, shift toward the MSB, feedback = XOR of the tap bits from LFSR_TAPS[N_IN] (maximal length). Produces 2^N_IN-1 distinct non-zero patterns; all-zero is never applied.
- Last pattern: the edge that compacts it moves RUN -> DONE and sets pass = (signature_next == golden_sig). cut_in then holds at 0.
- DONE:
  - done = 1; pass, signature and pattern_count hold.
  - start restarts directly (DONE -> RUN, same rules as from IDLE).
  - abort -> IDLE with done and pass cleared; signature is retained.
- abort in RUN: -> IDLE next edge; busy = 0, cut_in = 0, signature and pattern_count frozen.
- abort and start in the same cycle: abort wins.
- start in RUN: ignored.
- golden_sig: not registered at start.
- Width rules:
  - pattern_count is wide enough for 2^N_IN without wrap.
  - The exhaustive counter is N_IN+1 bits internally so the terminal compare needs no wrap logic.
  - N_OUT > SIG_W is a elaboration-time error.

Decomposition:
- Package bist_pkg holds:
  - state enumerated typedef (IDLE, RUN, DONE);
  - LFSR_TAPS constant table, indexed by width 3..16;
  - MISR_POLY constant for SIG_W = 16, value 16'h1021 (bit 0 always set).
- One sub-module: bist_misr, a parametrised SIG_W/N_OUT compactor with clear and enable inputs.
- Pattern generation and the FSM stay in the top module.

Test Plan:
- Exhaustive mode, N_IN = 5, CUT tied to 0, golden_sig = 0, start pulse -> cut_in steps 0..31 on consecutive cycles, busy high for exactly 32 cycles, then done = 1, pass = 1, pattern_count = 32, signature = 16'h0000.
- LFSR mode, N_IN = 5, CUT tied to 0 -> first cut_in = 5'b11111, 31 distinct non-zero patterns with no repeats, pattern_count = 31, done after 31 RUN cycles.
- Exhaustive mode, cut_out = (cut_in == 0) -> signature = 16'h0001 after the first RUN edge and 16'h8000 after 15 further edges.
- Any CUT with golden_sig set to the observed final signature XOR 16'h0001 -> pass = 0, done = 1.
- abort asserted at pattern_count = 10 -> IDLE next cycle, busy = 0, cut_in = 0, pattern_count holds 10. start during RUN has no effect on the sequence.
- rst_n pulled low at pattern_count = 7 (asynchronous, mid-cycle) -> all outputs 0 immediately; a new start then runs the full 32-pattern sequence.
